// File: rtl/mc_control_if.sv
// Control bundle between the multicycle main FSM and the datapath: IR fields
// and ALU flags in, datapath enables and selects out.
interface mc_control_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       more;
   logic       pcwrite;
   logic [1:0] pcsrc;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       extop;
   logic [1:0] aluop;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  op, funct, zero, more,
      output pcwrite, pcsrc, iord, memwrite, irwrite, regwrite, regdst,
             memtoreg, alusrca, alusrcb, extop, aluop, illegal, state
   );

   modport slave (
      output op, funct, zero, more,
      input  pcwrite, pcsrc, iord, memwrite, irwrite, regwrite, regdst,
             memtoreg, alusrca, alusrcb, extop, aluop, illegal, state
   );
endinterface

// File: rtl/mc_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALU op and operand selects; beq/bgtz resolve from the ALU flags.
module mc_control #(
   parameter bit HALT_ON_ILLEGAL = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   mc_control_if.master bus
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_OR   = 2'b10;
   localparam logic [1:0] ALU_SLT  = 2'b11;

   typedef enum logic [3:0] {
      S_INIT = 4'd0,
      S_IF   = 4'd1,
      S_ID   = 4'd2,
      S_EXR  = 4'd3,
      S_EXI  = 4'd4,
      S_WBA  = 4'd5,
      S_MADR = 4'd6,
      S_MRD  = 4'd7,
      S_MWR  = 4'd8,
      S_WBM  = 4'd9,
      S_BR   = 4'd10,
      S_JMP  = 4'd11,
      S_HALT = 4'd12
   } state_t;

   state_t     r_state;
   state_t     w_next;

   logic       r_pcwrite, r_iord, r_memwrite, r_irwrite, r_regwrite;
   logic       r_regdst, r_memtoreg, r_alusrca, r_extop;
   logic [1:0] r_pcsrc, r_alusrcb, r_aluop;

   logic       w_pcwrite, w_iord, w_memwrite, w_irwrite, w_regwrite;
   logic       w_regdst, w_memtoreg, w_alusrca, w_extop;
   logic [1:0] w_pcsrc, w_alusrcb, w_aluop;

   logic       w_rtype, w_addiu, w_ori, w_lw, w_sw, w_beq, w_bgtz, w_j;
   logic       w_r_legal, w_legal, w_br_take;
   logic [1:0] w_r_aluop;

   // Instruction decode straight off the (stable) IR fields
   assign w_rtype = (bus.op == OP_RTYPE);
   assign w_addiu = (bus.op == OP_ADDIU);
   assign w_ori   = (bus.op == OP_ORI);
   assign w_lw    = (bus.op == OP_LW);
   assign w_sw    = (bus.op == OP_SW);
   assign w_beq   = (bus.op == OP_BEQ);
   assign w_bgtz  = (bus.op == OP_BGTZ);
   assign w_j     = (bus.op == OP_J);

   always_comb begin
      w_r_aluop = ALU_ADD;
      w_r_legal = 1'b1;
      case (bus.funct)
         FN_ADDU: w_r_aluop = ALU_ADD;
         FN_SUBU: w_r_aluop = ALU_SUB;
         FN_OR:   w_r_aluop = ALU_OR;
         FN_SLT:  w_r_aluop = ALU_SLT;
         default: w_r_legal = 1'b0;
      endcase
   end

   assign w_legal = (w_rtype & w_r_legal) | w_addiu | w_ori | w_lw | w_sw |
                    w_beq | w_bgtz | w_j;

   // Next state and the control word that goes with it
   always_comb begin
      w_next     = S_IF;
      w_pcwrite  = 1'b0;
      w_pcsrc    = 2'b00;
      w_iord     = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_regdst   = 1'b0;
      w_memtoreg = 1'b0;
      w_alusrca  = 1'b0;
      w_alusrcb  = 2'b00;
      w_extop    = 1'b0;
      w_aluop    = ALU_ADD;

      case (r_state)
         S_IF: w_next = S_ID;
         S_ID: begin
            if (!w_legal)             w_next = HALT_ON_ILLEGAL ? S_HALT : S_IF;
            else if (w_rtype)         w_next = S_EXR;
            else if (w_addiu | w_ori) w_next = S_EXI;
            else if (w_lw | w_sw)     w_next = S_MADR;
            else if (w_beq | w_bgtz)  w_next = S_BR;
            else                      w_next = S_JMP;
         end
         S_EXR, S_EXI: w_next = S_WBA;
         S_MADR:       w_next = w_lw ? S_MRD : S_MWR;
         S_MRD:        w_next = S_WBM;
         S_HALT:       w_next = S_HALT;
         default:      w_next = S_IF;
      endcase

      case (w_next)
         S_IF: begin
            w_irwrite = 1'b1;
            w_alusrcb = 2'b01;
            w_pcwrite = 1'b1;
         end
         S_ID:  w_alusrcb = 2'b11;
         S_EXR: begin
            w_alusrca = 1'b1;
            w_aluop   = w_r_aluop;
         end
         S_EXI: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
            w_extop   = w_addiu;
            w_aluop   = w_ori ? ALU_OR : ALU_ADD;
         end
         S_WBA: begin
            w_regwrite = 1'b1;
            w_regdst   = w_rtype;
         end
         S_MADR: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
            w_extop   = 1'b1;
         end
         S_MRD: w_iord = 1'b1;
         S_MWR: begin
            w_iord     = 1'b1;
            w_memwrite = 1'b1;
         end
         S_WBM: begin
            w_regwrite = 1'b1;
            w_memtoreg = 1'b1;
         end
         S_BR: begin
            w_alusrca = 1'b1;
            w_aluop   = ALU_SUB;
            w_pcsrc   = 2'b01;
         end
         S_JMP: begin
            w_pcsrc   = 2'b10;
            w_pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_INIT;
         r_pcwrite  <= 1'b0;
         r_pcsrc    <= 2'b00;
         r_iord     <= 1'b0;
         r_memwrite <= 1'b0;
         r_irwrite  <= 1'b0;
         r_regwrite <= 1'b0;
         r_regdst   <= 1'b0;
         r_memtoreg <= 1'b0;
         r_alusrca  <= 1'b0;
         r_alusrcb  <= 2'b00;
         r_extop    <= 1'b0;
         r_aluop    <= ALU_ADD;
      end else begin
         r_state    <= w_next;
         r_pcwrite  <= w_pcwrite;
         r_pcsrc    <= w_pcsrc;
         r_iord     <= w_iord;
         r_memwrite <= w_memwrite;
         r_irwrite  <= w_irwrite;
         r_regwrite <= w_regwrite;
         r_regdst   <= w_regdst;
         r_memtoreg <= w_memtoreg;
         r_alusrca  <= w_alusrca;
         r_alusrcb  <= w_alusrcb;
         r_extop    <= w_extop;
         r_aluop    <= w_aluop;
      end
   end

   // Branch outcome and illegal flag need the flags/IR of the current cycle
   assign w_br_take    = (r_state == S_BR) & (w_bgtz ? bus.more : bus.zero);
   assign bus.illegal  = (r_state == S_ID) & ~w_legal;

   assign bus.pcwrite  = r_pcwrite | w_br_take;
   assign bus.pcsrc    = r_pcsrc;
   assign bus.iord     = r_iord;
   assign bus.memwrite = r_memwrite;
   assign bus.irwrite  = r_irwrite;
   assign bus.regwrite = r_regwrite;
   assign bus.regdst   = r_regdst;
   assign bus.memtoreg = r_memtoreg;
   assign bus.alusrca  = r_alusrca;
   assign bus.alusrcb  = r_alusrcb;
   assign bus.extop    = r_extop;
   assign bus.aluop    = r_aluop;
   assign bus.state    = r_state;

endmodule
